// File: rtl/uart_receiver.sv
// uart_receiver: oversampling UART receiver (start, DATA_SIZE bits LSB
// first, stop). Ports: clk, reset (sync, active-high), serial_data_in in;
// data_out, rx_done (1-cycle pulse), frame_error, rx_busy out.
// Define UART_RX_PARITY_EN to add an even-parity bit before the stop bit
// and the parity_error output.
module uart_receiver #(
    parameter int DATA_SIZE       = 8,
    parameter int CLKS_PER_BIT    = 16,
    parameter int BIT_COUNT_SIZE  = $clog2(DATA_SIZE + 1),
    parameter int SAMPLE_CNT_SIZE =
        (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 serial_data_in,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 rx_done,
    output logic                 frame_error,
`ifdef UART_RX_PARITY_EN
    output logic                 parity_error,
`endif
    output logic                 rx_busy
);

    localparam logic [SAMPLE_CNT_SIZE-1:0] HALF =
        SAMPLE_CNT_SIZE'((CLKS_PER_BIT - 1) / 2);
    localparam logic [SAMPLE_CNT_SIZE-1:0] LAST =
        SAMPLE_CNT_SIZE'(CLKS_PER_BIT - 1);
    localparam logic [BIT_COUNT_SIZE-1:0] LAST_BIT =
        BIT_COUNT_SIZE'(DATA_SIZE - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        RECOVER
    } state_t;

    state_t                     state;
    logic                       sync1;
    logic                       sync2;
    logic                       s;
    logic [SAMPLE_CNT_SIZE-1:0] cnt;
    logic [BIT_COUNT_SIZE-1:0]  bit_cnt;
    logic [DATA_SIZE-1:0]       shift_reg;
    logic [DATA_SIZE-1:0]       shift_next;
`ifdef UART_RX_PARITY_EN
    logic                       parity_bit;
`endif

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= serial_data_in;
            sync2 <= sync1;
        end
    end

    assign s = sync2;

    // Bits arrive LSB first, so each new sample enters at the MSB.
    always_comb begin
        shift_next                = shift_reg >> 1;
        shift_next[DATA_SIZE-1]   = s;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            data_out    <= '0;
            rx_done     <= 1'b0;
            frame_error <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_bit   <= 1'b0;
            parity_error <= 1'b0;
`endif
        end else begin
            rx_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!s) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end
                // Re-check the start bit at its centre to reject glitches.
                START: begin
                    if (cnt != HALF) begin
                        cnt <= cnt + 1'b1;
                    end else if (!s) begin
                        state   <= DATA;
                        cnt     <= '0;
                        bit_cnt <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                DATA: begin
                    if (cnt != LAST) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt       <= '0;
                        shift_reg <= shift_next;
                        bit_cnt   <= bit_cnt + 1'b1;
                        if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt != LAST) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt        <= '0;
                        parity_bit <= s;
                        state      <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (cnt != LAST) begin
                        cnt <= cnt + 1'b1;
                    end else begin
                        cnt         <= '0;
                        data_out    <= shift_reg;
                        rx_done     <= 1'b1;
                        frame_error <= ~s;
`ifdef UART_RX_PARITY_EN
                        parity_error <= (^shift_reg) ^ parity_bit;
`endif
                        // A low stop bit may be a break: wait for the
                        // line to return high before hunting for a start.
                        state <= s ? IDLE : RECOVER;
                    end
                end
                RECOVER: begin
                    if (s) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign rx_busy = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames into uart_receiver; a scoreboard
// queue holds expected words, a monitor checks them on each rx_done.
module tb_uart_receiver;

    localparam int C = 16;
    localparam int H = (C - 1) / 2;
`ifdef UART_RX_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       serial_data_in = 1'b1;
    logic [7:0] data_out;
    logic       rx_done;
    logic       frame_error;
    logic       rx_busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_error;
`endif

    typedef struct {
        logic [7:0] d;
        logic       fe;
        logic       pe;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    uart_receiver #(
        .DATA_SIZE    (8),
        .CLKS_PER_BIT (C)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .serial_data_in (serial_data_in),
        .data_out       (data_out),
        .rx_done        (rx_done),
        .frame_error    (frame_error),
`ifdef UART_RX_PARITY_EN
        .parity_error   (parity_error),
`endif
        .rx_busy        (rx_busy)
    );

    always #5 clk = ~clk;

    // Edge counter; read only on falling edges.
    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called on a falling edge; returns on the falling edge that ends
    // the stop bit. The start bit is captured by the DUT's first
    // synchroniser flop at edge cyc+1.
    task automatic send(input logic [7:0] d,
                        input logic stop,
                        input logic pb);
        exp_t e;
        serial_data_in = 1'b0;
        e.d   = d;
        e.fe  = ~stop;
        e.pe  = (^d) ^ pb;
        e.cyc = cyc + 1 + 3 + H + (NB + 1) * C;
        sb.push_back(e);
        repeat (C) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            serial_data_in = d[i];
            repeat (C) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        serial_data_in = pb;
        repeat (C) @(negedge clk);
`endif
        serial_data_in = stop;
        repeat (C) @(negedge clk);
    endtask

    // Monitor: every rx_done must match the oldest expected frame.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset && rx_done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_rx_done: got rx_done=1 at edge %0d, expected none",
                             cyc);
                end else begin
                    e = sb.pop_front();
                    check("data_out", 32'(data_out), 32'(e.d));
                    check("frame_error", 32'(frame_error), 32'(e.fe));
                    check("done_edge", cyc, e.cyc);
`ifdef UART_RX_PARITY_EN
                    check("parity_error", 32'(parity_error), 32'(e.pe));
`endif
                end
            end
        end
    end

    initial begin
        logic [7:0] v;
        repeat (3) @(negedge clk);
        check("rst_data_out", 32'(data_out), 32'h0);
        check("rst_rx_done", 32'(rx_done), 32'h0);
        check("rst_frame_error", 32'(frame_error), 32'h0);
        check("rst_rx_busy", 32'(rx_busy), 32'h0);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        // Plain frame.
        send(8'hCB, 1'b1, 1'b1);
        check("busy_after_cb", 32'(rx_busy), 32'h0);
        repeat (C) @(negedge clk);

        // Four-cycle glitch must be rejected.
        serial_data_in = 1'b0;
        repeat (4) @(negedge clk);
        serial_data_in = 1'b1;
        repeat (3 * C) @(negedge clk);
        check("glitch_busy", 32'(rx_busy), 32'h0);
        check("glitch_data_out", 32'(data_out), 32'hCB);

        // Bad stop bit, line held low, then a good frame.
        send(8'h55, 1'b0, 1'b0);
        repeat (40) @(negedge clk);
        check("busy_recover", 32'(rx_busy), 32'h1);
        serial_data_in = 1'b1;
        repeat (5) @(negedge clk);
        check("busy_after_recover", 32'(rx_busy), 32'h0);
        send(8'hA3, 1'b1, 1'b0);
        repeat (C) @(negedge clk);

        // Back-to-back frames, no idle gap.
        send(8'h00, 1'b1, 1'b0);
        send(8'hFF, 1'b1, 1'b0);
        repeat (C) @(negedge clk);

        // Reset in the middle of data bit 3 of 0x3C.
        v = 8'h3C;
        serial_data_in = 1'b0;
        repeat (C) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            serial_data_in = v[i];
            repeat (C) @(negedge clk);
        end
        serial_data_in = v[3];
        repeat (C / 2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        serial_data_in = 1'b1;
        check("midrst_data_out", 32'(data_out), 32'h0);
        check("midrst_frame_error", 32'(frame_error), 32'h0);
        check("midrst_rx_busy", 32'(rx_busy), 32'h0);
        check("midrst_rx_done", 32'(rx_done), 32'h0);
        repeat (2 * C) @(negedge clk);
        send(8'h81, 1'b1, 1'b0);
        repeat (C) @(negedge clk);

`ifdef UART_RX_PARITY_EN
        // 0x07 has three ones: parity 0 is an error, parity 1 is not.
        send(8'h07, 1'b1, 1'b0);
        send(8'h07, 1'b1, 1'b1);
        repeat (C) @(negedge clk);
`endif

        repeat (2 * C) @(negedge clk);
        check("pending_frames", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish by 100000 cycles, expected finish");
        $fatal(1, "timeout");
    end

endmodule
